triangle_assembler: RTL

Consumer end of the vertex FIFO fed by the geometry engine. Pops screen-space vertices three at a time and computes the signed area and a screen-clamped bounding box for each triangle. Drops degenerate, off-screen and (optionally) back-facing triangles. Surviving triangles go to the rasterizer over a valid/ready handshake.

---
 rtl/tri_pkg.sv | 38 +++
 rtl/tri_setup_unit.sv | 100 ++++++++++
 rtl/triangle_assembler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// tri_pkg: shared vertex layout, screen defaults, FSM states and clamp helper for the triangle assembler.
// Latency: none (types and constants only).
// Backpressure: n/a.
package tri_pkg;

  localparam int VTX_W        = 136;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  // Field order matches the FIFO word: x at the top, v at the bottom.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  z;
    logic [31:0] u;
    logic [31:0] v;
  } vertex_t;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_CAPTURE = 2'd1,
    S_SETUP   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  // Clamp a signed integer pixel coordinate into [0, hi].
  function automatic logic [9:0] clamp_coord(input logic signed [15:0] c,
                                             input logic signed [15:0] hi);
    if (c < 16'sd0) begin
      return 10'd0;
    end else if (c > hi) begin
      return hi[9:0];
    end else begin
      return c[9:0];
    end
  endfunction

endpackage

// File: rtl/tri_setup_unit.sv
// tri_setup_unit: signed doubled area, screen-clamped bounding box and drop flag for three vertices.
// Latency: 1 cycle; outputs update on the cycle after start and hold otherwise.
// Backpressure: none; TRI_BACKFACE_CULL_EN also flags negative-area triangles for dropping.
module tri_setup_unit
  import tri_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        start,
  input  vertex_t     vtx0,
  input  vertex_t     vtx1,
  input  vertex_t     vtx2,
  output logic [34:0] area,
  output logic [9:0]  xmin,
  output logic [9:0]  xmax,
  output logic [9:0]  ymin,
  output logic [9:0]  ymax,
  output logic        drop
);

  localparam logic signed [15:0] X_HI = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_HI = 16'(SCREEN_H - 1);

  logic signed [15:0] x0, x1, x2, y0, y1, y2;
  logic signed [15:0] xmn, xmx, ymn, ymx;
  logic        [16:0] dx1, dy1, dx2, dy2;
  logic        [33:0] prod_a, prod_b;
  logic        [34:0] area_c;
  logic               off_screen, back_face, drop_c;

  // Fractions, depth and texture coordinates play no part in setup.
  logic unused_bits;
  assign unused_bits = ^{vtx0.x[15:0], vtx0.y[15:0], vtx0.z, vtx0.u, vtx0.v,
                         vtx1.x[15:0], vtx1.y[15:0], vtx1.z, vtx1.u, vtx1.v,
                         vtx2.x[15:0], vtx2.y[15:0], vtx2.z, vtx2.u, vtx2.v};

  assign x0 = vtx0.x[31:16];
  assign x1 = vtx1.x[31:16];
  assign x2 = vtx2.x[31:16];
  assign y0 = vtx0.y[31:16];
  assign y1 = vtx1.y[31:16];
  assign y2 = vtx2.y[31:16];

  // Full-precision edge cross product: 17-bit deltas, 34-bit products, 35-bit result.
  always_comb begin
    dx1    = {x1[15], x1} - {x0[15], x0};
    dy1    = {y1[15], y1} - {y0[15], y0};
    dx2    = {x2[15], x2} - {x0[15], x0};
    dy2    = {y2[15], y2} - {y0[15], y0};
    prod_a = {{17{dx1[16]}}, dx1} * {{17{dy2[16]}}, dy2};
    prod_b = {{17{dx2[16]}}, dx2} * {{17{dy1[16]}}, dy1};
    area_c = {prod_a[33], prod_a} - {prod_b[33], prod_b};
  end

  // Unclamped box and the drop decision.
  always_comb begin
    xmn = x0;
    xmx = x0;
    ymn = y0;
    ymx = y0;
    if (x1 < xmn) xmn = x1;
    if (x2 < xmn) xmn = x2;
    if (x1 > xmx) xmx = x1;
    if (x2 > xmx) xmx = x2;
    if (y1 < ymn) ymn = y1;
    if (y2 < ymn) ymn = y2;
    if (y1 > ymx) ymx = y1;
    if (y2 > ymx) ymx = y2;
    off_screen = xmx[15] || (xmn > X_HI) || ymx[15] || (ymn > Y_HI);
`ifdef TRI_BACKFACE_CULL_EN
    back_face  = area_c[34];
`else
    back_face  = 1'b0;
`endif
    drop_c     = (area_c == 35'd0) || off_screen || back_face;
  end

  // Register the setup results on start; hold them otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      area <= '0;
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
      drop <= 1'b0;
    end else if (start) begin
      area <= area_c;
      xmin <= clamp_coord(xmn, X_HI);
      xmax <= clamp_coord(xmx, X_HI);
      ymin <= clamp_coord(ymn, Y_HI);
      ymax <= clamp_coord(ymx, Y_HI);
      drop <= drop_c;
    end
  end

endmodule

// File: rtl/triangle_assembler.sv
// triangle_assembler: pops vertices three at a time, sets up area/bbox, culls, hands triangles to the rasterizer.
// Latency: o_tri_valid rises 3 cycles after the third pop; peak one triangle per 8 cycles.
// Backpressure: payload held while i_tri_ready is low, no pops meanwhile; TRI_BACKFACE_CULL_EN drops negative area.
module triangle_assembler
  import tri_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enabled,
  input  logic             i_frame_start,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  input  logic [VTX_W-1:0] i_vtx_data,
  output logic             o_tri_valid,
  input  logic             i_tri_ready,
  output logic [VTX_W-1:0] o_vtx0,
  output logic [VTX_W-1:0] o_vtx1,
  output logic [VTX_W-1:0] o_vtx2,
  output logic [34:0]      o_area,
  output logic [9:0]       o_xmin,
  output logic [9:0]       o_xmax,
  output logic [9:0]       o_ymin,
  output logic [9:0]       o_ymax,
  output logic [15:0]      o_tri_count,
  output logic [15:0]      o_cull_count
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        capture, setup_go, load_out, cull, accept;
  vertex_t     slot0, slot1, slot2;
  logic [34:0] su_area;
  logic [9:0]  su_xmin, su_xmax, su_ymin, su_ymax;
  logic        su_drop;

  // Setup starts during the third capture, so the newest vertex comes straight from the FIFO bus.
  tri_setup_unit #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_setup (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .start (setup_go),
    .vtx0  (slot0),
    .vtx1  (slot1),
    .vtx2  (vertex_t'(i_vtx_data)),
    .area  (su_area),
    .xmin  (su_xmin),
    .xmax  (su_xmax),
    .ymin  (su_ymin),
    .ymax  (su_ymax),
    .drop  (su_drop)
  );

  // Next-state and control strobes; frame start abandons a partial triangle but never an offered one.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    o_fifo_rd_en = 1'b0;
    capture      = 1'b0;
    setup_go     = 1'b0;
    load_out     = 1'b0;
    cull         = 1'b0;
    accept       = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (i_frame_start) begin
          idx_d = 2'd0;
        end else if (i_enabled && !i_fifo_empty && !i_rst) begin
          o_fifo_rd_en = 1'b1;
          state_d      = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_FETCH;
        if (i_frame_start) begin
          idx_d = 2'd0;
        end else begin
          capture = 1'b1;
          if (idx_q == 2'd2) begin
            setup_go = 1'b1;
            idx_d    = 2'd0;
            state_d  = S_SETUP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_FETCH;
        idx_d   = 2'd0;
        if (!i_frame_start) begin
          if (su_drop) begin
            cull = 1'b1;
          end else begin
            load_out = 1'b1;
            state_d  = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (i_tri_ready) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State and vertex index registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Vertex slots, filled in FIFO order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot0 <= '0;
      slot1 <= '0;
      slot2 <= '0;
    end else if (capture) begin
      case (idx_q)
        2'd0:    slot0 <= vertex_t'(i_vtx_data);
        2'd1:    slot1 <= vertex_t'(i_vtx_data);
        default: slot2 <= vertex_t'(i_vtx_data);
      endcase
    end
  end

  // Output payload, handshake and counters; payload only changes when a new triangle is offered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tri_valid  <= 1'b0;
      o_vtx0       <= '0;
      o_vtx1       <= '0;
      o_vtx2       <= '0;
      o_area       <= '0;
      o_xmin       <= '0;
      o_xmax       <= '0;
      o_ymin       <= '0;
      o_ymax       <= '0;
      o_tri_count  <= '0;
      o_cull_count <= '0;
    end else begin
      if (load_out) begin
        o_tri_valid <= 1'b1;
        o_vtx0      <= slot0;
        o_vtx1      <= slot1;
        o_vtx2      <= slot2;
        o_area      <= su_area;
        o_xmin      <= su_xmin;
        o_xmax      <= su_xmax;
        o_ymin      <= su_ymin;
        o_ymax      <= su_ymax;
      end
      if (accept) begin
        o_tri_valid <= 1'b0;
        o_tri_count <= o_tri_count + 16'd1;
      end
      if (cull) begin
        o_cull_count <= o_cull_count + 16'd1;
      end
    end
  end

endmodule
